// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the multi-port cache bank:
//   DEFAULT_DATA_WIDTH - default word width in bits (multiple of 8)
//   DEFAULT_ADDR_WIDTH - default line address width (DEPTH = 2**ADDR_WIDTH)
//   flushState_t       - states of the bank-clear sequencer
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } flushState_t;

endpackage

// File: rtl/cache_flush_sequencer.sv
// -----------------------------------------------------------------------------
// cache_flush_sequencer
// Walks a line counter over the whole bank, one line per cycle, after a start
// pulse received in IDLE. Ends with a one-cycle DONE state.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high; aborts a running flush silently
//   start      - flush request pulse, honoured only in IDLE
//   busy       - high in FLUSH and DONE (the bank refuses port requests)
//   lineIndex  - line to clear this cycle
//   lineClear  - strobe: zero line lineIndex and clear its written bit
//   done       - one-cycle pulse while in DONE
// -----------------------------------------------------------------------------
import cache_pkg::*;

module cache_flush_sequencer #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] lineIndex,
    output logic                  lineClear,
    output logic                  done
);

    flushState_t           state;
    logic [ADDR_WIDTH-1:0] count;

    // NOTE: all state and outputs here are flops, so every assignment is
    // non-blocking; blocking assignments would make the update order matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            lineClear <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FLUSH;
                        count     <= '0;
                        busy      <= 1'b1;
                        lineClear <= 1'b1;
                    end
                end
                FLUSH: begin
                    // All-ones is the last line of the bank.
                    if (count == '1) begin
                        state     <= DONE;
                        lineClear <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    lineClear <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign lineIndex = count;

endmodule

// File: rtl/multi_port_cache_bank.sv
// -----------------------------------------------------------------------------
// multi_port_cache_bank
// DEPTH lines of DATA_WIDTH bits with a per-line "written" flag, accessed by
// PORTS independent ports (legal range 1..4) with byte-enabled writes and
// 1-cycle registered reads, plus a full-bank flush sequence.
// Ports:
//   clk, reset      - clock (rising edge); synchronous active-high reset
//   req, we         - per-port request and write enable (1 = write)
//   addr            - per-port line address, port i in slice i
//   wdata, be       - per-port write data and byte enables
//   flush_start     - pulse requesting a full bank clear
//   rdata, written  - per-port read data / written flag, held between reads
//   rvalid          - per-port one-cycle pulse: rdata/written updated
//   conflict        - per-port one-cycle pulse: this port's write was dropped
//   ready           - high while port requests are accepted (not flushing)
//   flush_done      - one-cycle pulse at the end of a flush
// -----------------------------------------------------------------------------
import cache_pkg::*;

module multi_port_cache_bank #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int PORTS      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PORTS-1:0]              req,
    input  logic [PORTS-1:0]              we,
    input  logic [PORTS*ADDR_WIDTH-1:0]   addr,
    input  logic [PORTS*DATA_WIDTH-1:0]   wdata,
    input  logic [PORTS*DATA_WIDTH/8-1:0] be,
    input  logic                          flush_start,
    output logic [PORTS*DATA_WIDTH-1:0]   rdata,
    output logic [PORTS-1:0]              rvalid,
    output logic [PORTS-1:0]              written,
    output logic [PORTS-1:0]              conflict,
    output logic                          ready,
    output logic                          flush_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] lines [DEPTH];
    logic [DEPTH-1:0]      writtenVec;

    logic                  busy;
    logic                  lineClear;
    logic [ADDR_WIDTH-1:0] lineIndex;

    logic [PORTS-1:0] wantWrite;
    logic [PORTS-1:0] dropWrite;
    logic [PORTS-1:0] doWrite;
    logic [PORTS-1:0] doRead;

    cache_flush_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_flushSeq (
        .clk       (clk),
        .reset     (reset),
        .start     (flush_start),
        .busy      (busy),
        .lineIndex (lineIndex),
        .lineClear (lineClear),
        .done      (flush_done)
    );

    assign ready = !busy;

    // Write arbitration: a write with no byte enabled is not a write at all,
    // so it neither wins nor loses. Among real writes to one address the
    // lowest-index port wins outright; the others are dropped unmerged.
    // NOTE: every output of this block gets a default before the loops, so no
    // path leaves a bit unassigned and no latch is inferred.
    always_comb begin
        wantWrite = '0;
        doRead    = '0;
        dropWrite = '0;
        for (int i = 0; i < PORTS; i++) begin
            wantWrite[i] = ready && req[i] && we[i] && (|be[i*BYTES +: BYTES]);
            doRead[i]    = ready && req[i] && !we[i];
        end
        for (int i = 1; i < PORTS; i++) begin
            for (int j = 0; j < i; j++) begin
                if (wantWrite[i] && wantWrite[j] &&
                    addr[i*ADDR_WIDTH +: ADDR_WIDTH] == addr[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    dropWrite[i] = 1'b1;
                end
            end
        end
        doWrite = wantWrite & ~dropWrite;
    end

    // NOTE: the line storage has no reset; only the written vector is
    // cleared, which is what tells a reader a line holds real data.
    always_ff @(posedge clk) begin
        if (lineClear) begin
            lines[lineIndex] <= '0;
        end
        // Surviving writes always target distinct lines, so order is moot.
        for (int i = 0; i < PORTS; i++) begin
            if (doWrite[i]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be[i*BYTES + b]) begin
                        lines[addr[i*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] <=
                            wdata[i*DATA_WIDTH + b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            writtenVec <= '0;
        end else begin
            if (lineClear) begin
                writtenVec[lineIndex] <= 1'b0;
            end
            for (int i = 0; i < PORTS; i++) begin
                if (doWrite[i]) begin
                    writtenVec[addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
                end
            end
        end
    end

    // Read registers sample the pre-edge contents, so a same-cycle write to
    // the read address is not visible until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            rvalid   <= '0;
            written  <= '0;
            conflict <= '0;
        end else begin
            conflict <= dropWrite;
            rvalid   <= doRead;
            for (int i = 0; i < PORTS; i++) begin
                if (doRead[i]) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] <= lines[addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                    written[i] <= writtenVec[addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_port_cache_bank.sv
// -----------------------------------------------------------------------------
// tb_multi_port_cache_bank
// Table-driven bench for multi_port_cache_bank at its defaults (32-bit words,
// 64 lines, 2 ports). Each applied cycle pushes its expected outputs into a
// scoreboard queue; a monitor pops one entry per cycle and compares rvalid,
// conflict, and the per-port rdata/written (which must hold between reads).
// -----------------------------------------------------------------------------
module tb_multi_port_cache_bank;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NP = 2;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    req;
    logic [NP-1:0]    we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic [NP*DW/8-1:0] be;
    logic             flush_start;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    rvalid;
    logic [NP-1:0]    written;
    logic [NP-1:0]    conflict;
    logic             ready;
    logic             flush_done;

    multi_port_cache_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PORTS      (NP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .be          (be),
        .flush_start (flush_start),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .written     (written),
        .conflict    (conflict),
        .ready       (ready),
        .flush_done  (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected after the edge that
    // consumes it.
    typedef struct packed {
        logic        rst;
        logic        fs;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [5:0]  a0;
        logic [5:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [1:0]  rv;
        logic [1:0]  cf;
        logic [31:0] r0;
        logic [31:0] r1;
        logic        w0;
        logic        w1;
    } stim_t;

    stim_t sb[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(
        input int unsigned rq, input int unsigned w,
        input int unsigned a0, input int unsigned d0, input int unsigned be0,
        input int unsigned a1, input int unsigned d1, input int unsigned be1,
        input int unsigned rv,
        input int unsigned r0, input int unsigned w0,
        input int unsigned r1, input int unsigned w1,
        input int unsigned cf);
        stim_t s;
        s.rst = 1'b0;
        s.fs  = 1'b0;
        s.req = 2'(rq);
        s.we  = 2'(w);
        s.a0  = 6'(a0);
        s.a1  = 6'(a1);
        s.d0  = d0;
        s.d1  = d1;
        s.be0 = 4'(be0);
        s.be1 = 4'(be1);
        s.rv  = 2'(rv);
        s.cf  = 2'(cf);
        s.r0  = r0;
        s.r1  = r1;
        s.w0  = 1'(w0);
        s.w1  = 1'(w1);
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Drive one cycle (called just after an edge), wait for the consuming
    // edge, queue the expectation, then step off the edge.
    task automatic step(input stim_t s);
        reset       = s.rst;
        flush_start = s.fs;
        req         = s.req;
        we          = s.we;
        addr        = {s.a1, s.a0};
        wdata       = {s.d1, s.d0};
        be          = {s.be1, s.be0};
        @(posedge clk);
        sb.push_back(s);
        #1;
    endtask

    task automatic monitor();
        stim_t       e;
        logic [31:0] last0;
        logic [31:0] last1;
        logic        lw0;
        logic        lw1;
        last0 = '0;
        last1 = '0;
        lw0   = 1'b0;
        lw1   = 1'b0;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.rst) begin
                    last0 = '0;
                    last1 = '0;
                    lw0   = 1'b0;
                    lw1   = 1'b0;
                end else begin
                    if (e.rv[0]) begin
                        last0 = e.r0;
                        lw0   = e.w0;
                    end
                    if (e.rv[1]) begin
                        last1 = e.r1;
                        lw1   = e.w1;
                    end
                end
                check("rvalid", 64'(rvalid), 64'(e.rv));
                check("conflict", 64'(conflict), 64'(e.cf));
                check("rdata0", 64'(rdata[31:0]), 64'(last0));
                check("rdata1", 64'(rdata[63:32]), 64'(last1));
                check("written0", 64'(written[0]), 64'(lw0));
                check("written1", 64'(written[1]), 64'(lw1));
            end
        end
    endtask

    // Start a flush with the given first-cycle stimulus and count how long
    // ready stays low. With noisy set, requests and a second flush_start are
    // thrown at the bank while it is busy; all must be ignored.
    task automatic runFlush(input stim_t first, input bit noisy, input string tag);
        int    lows;
        int    dones;
        int    doneAt;
        stim_t s;
        first.fs = 1'b1;
        step(first);
        lows   = 0;
        dones  = 0;
        doneAt = 0;
        for (int i = 0; i < 200; i++) begin
            if (ready) break;
            lows++;
            if (flush_done) begin
                dones++;
                doneAt = lows;
            end
            s = idle();
            if (noisy && lows == 5)  s = mk(3, 1, 0, 32'h0000FFFF, 4'hF, 5, 0, 0, 0, 0, 0, 0, 0, 0);
            if (noisy && lows == 10) s.fs = 1'b1;
            step(s);
        end
        check({tag, " ready-low cycles"}, 64'(lows), 64'd65);
        check({tag, " flush_done pulses"}, 64'(dones), 64'd1);
        check({tag, " flush_done position"}, 64'(doneAt), 64'd65);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    stim_t tblA [15];
    stim_t tblB [6];
    stim_t s;

    initial begin
        //            req we  a0  d0            be0   a1  d1            be1  rv  r0            w0 r1            w1 cf
        tblA[0]  = mk(1, 1,   5,  32'hDEADBEEF, 4'hF, 0,  0,            0,   0,  0,            0, 0,            0, 0);
        tblA[1]  = mk(2, 0,   0,  0,            0,    5,  0,            0,   2,  0,            0, 32'hDEADBEEF, 1, 0);
        tblA[2]  = mk(1, 1,   5,  32'h00001234, 4'h3, 0,  0,            0,   0,  0,            0, 0,            0, 0);
        tblA[3]  = mk(1, 0,   5,  0,            0,    0,  0,            0,   1,  32'hDEAD1234, 1, 0,            0, 0);
        tblA[4]  = mk(3, 3,   9,  32'h11,       4'hF, 9,  32'h22,       4'hF, 0, 0,            0, 0,            0, 2);
        tblA[5]  = mk(3, 0,   9,  0,            0,    5,  0,            0,   3,  32'h11,       1, 32'hDEAD1234, 1, 0);
        tblA[6]  = mk(1, 1,   3,  32'h55,       4'hF, 0,  0,            0,   0,  0,            0, 0,            0, 0);
        tblA[7]  = mk(3, 1,   3,  32'hAA,       4'hF, 3,  0,            0,   2,  0,            0, 32'h55,       1, 0);
        tblA[8]  = mk(1, 0,   3,  0,            0,    0,  0,            0,   1,  32'hAA,       1, 0,            0, 0);
        tblA[9]  = mk(3, 3,   10, 32'h1010,     4'hF, 11, 32'h1111,     4'hF, 0, 0,            0, 0,            0, 0);
        tblA[10] = mk(3, 0,   11, 0,            0,    10, 0,            0,   3,  32'h1111,     1, 32'h1010,     1, 0);
        tblA[11] = mk(3, 3,   12, 32'hFFFFFFFF, 4'h0, 12, 32'h12345678, 4'hF, 0, 0,            0, 0,            0, 0);
        tblA[12] = mk(1, 0,   12, 0,            0,    0,  0,            0,   1,  32'h12345678, 1, 0,            0, 0);
        tblA[13] = mk(2, 2,   0,  0,            0,    12, 32'hAB000000, 4'h8, 0, 0,            0, 0,            0, 0);
        tblA[14] = mk(2, 0,   0,  0,            0,    12, 0,            0,   2,  0,            0, 32'hAB345678, 1, 0);

        // Applied after a full flush, so every line starts at zero.
        tblB[0]  = mk(1, 1,   20, 32'hFFFFFFFF, 4'h0, 0,  0,            0,   0,  0,            0, 0,            0, 0);
        tblB[1]  = mk(1, 0,   20, 0,            0,    0,  0,            0,   1,  0,            0, 0,            0, 0);
        tblB[2]  = mk(3, 3,   21, 32'h77,       4'hF, 21, 32'h99,       4'h0, 0, 0,            0, 0,            0, 0);
        tblB[3]  = mk(1, 0,   21, 0,            0,    0,  0,            0,   1,  32'h77,       1, 0,            0, 0);
        tblB[4]  = mk(3, 1,   22, 32'hAA,       4'hF, 22, 0,            0,   2,  0,            0, 0,            0, 0);
        tblB[5]  = mk(3, 0,   21, 0,            0,    22, 0,            0,   3,  32'h77,       1, 32'hAA,       1, 0);

        fork
            monitor();
        join_none

        // Reset.
        s = idle();
        s.rst = 1'b1;
        step(s);
        step(s);
        check("ready after reset", 64'(ready), 64'd1);
        check("flush_done after reset", 64'(flush_done), 64'd0);

        for (int i = 0; i < 15; i++) step(tblA[i]);

        // Flush with a read in the start cycle, noise while busy, then a sweep.
        runFlush(mk(1, 0, 5, 0, 0, 0, 0, 0, 1, 32'hDEAD1234, 1, 0, 0, 0), 1'b1, "flush1");
        for (int a = 0; a < 64; a++) begin
            step(mk(3, 0, a, 0, 0, 63 - a, 0, 0, 3, 0, 0, 0, 0, 0));
        end

        for (int i = 0; i < 6; i++) step(tblB[i]);

        // Reset ten cycles into a flush.
        s = idle();
        s.fs = 1'b1;
        step(s);
        for (int i = 0; i < 10; i++) step(idle());
        check("ready low mid-flush", 64'(ready), 64'd0);
        s = idle();
        s.rst = 1'b1;
        step(s);
        check("ready after abort", 64'(ready), 64'd1);
        check("flush_done after abort", 64'(flush_done), 64'd0);
        step(idle());
        check("flush_done stays low", 64'(flush_done), 64'd0);
        // Lines 21/22 were beyond the aborted counter: data kept, flags cleared.
        step(mk(3, 0, 21, 0, 0, 22, 0, 0, 3, 32'h77, 0, 32'hAA, 0, 0));
        step(mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0));

        runFlush(idle(), 1'b0, "flush2");
        step(mk(3, 0, 21, 0, 0, 22, 0, 0, 3, 0, 0, 0, 0, 0));
        step(idle());

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
